lieat_exu_com_csrctrl: RTL and testbench

Sequencer and arbiter for the single commit-stage CSR register port (ena/write/idx/wdata/rdata). It shares the port between three requesters: the CSR-instruction unit, the trap-entry request (ecall/exception) and the mret request. Trap entry and mret run as multi-cycle FSM sequences of read-modify-write steps on mepc, mcause, mstatus and mtvec. Each sequence ends with a PC redirect to the fetch stage.

---
 rtl/lieat_exu_com_csrctrl_pkg.sv | 25 ++
 rtl/lieat_exu_com_csrctrl.sv | 144 ++++++++++++++
 tb/tb_lieat_exu_com_csrctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lieat_exu_com_csrctrl_pkg.sv
// Shared constants for the commit-stage CSR sequencer: CSR addresses,
// mstatus field positions and the sequencer state encoding.
package lieat_exu_com_csrctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_T_EPC   = 3'd1,
    S_T_CAUSE = 3'd2,
    S_T_STAT  = 3'd3,
    S_T_VEC   = 3'd4,
    S_M_STAT  = 3'd5,
    S_M_EPC   = 3'd6
  } csr_state_e;

endpackage

// File: rtl/lieat_exu_com_csrctrl.sv
// Arbitrates the single commit-stage CSR port between CSR instructions,
// trap entry and mret; trap/mret run as short RMW sequences ending in a redirect.
module lieat_exu_com_csrctrl
  import lieat_exu_com_csrctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CSR_IDX = 12
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ins_valid,
  output logic               ins_ready,
  input  logic               ins_write,
  input  logic [CSR_IDX-1:0] ins_idx,
  input  logic [XLEN-1:0]    ins_wdata,
  output logic [XLEN-1:0]    ins_rdata,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [XLEN-1:0]    trap_cause,
  output logic               trap_ready,
  input  logic               mret_valid,
  output logic               mret_ready,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               csr_ena,
  output logic               csr_write,
  output logic [CSR_IDX-1:0] csr_idx,
  output logic [XLEN-1:0]    csr_wdata,
  input  logic [XLEN-1:0]    csr_rdata,
  output logic               busy
);

  csr_state_e      state, state_nxt;
  logic [XLEN-1:0] pc_q, cause_q;
  logic [XLEN-1:0] stat_trap, stat_mret;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && trap_valid) begin
        pc_q    <= trap_pc;
        cause_q <= trap_cause;
      end
    end
  end

  // mstatus images for trap entry and mret, formed from the live read data
  always_comb begin
    stat_trap                   = csr_rdata;
    stat_trap[MPIE_BIT]         = csr_rdata[MIE_BIT];
    stat_trap[MIE_BIT]          = 1'b0;
    stat_trap[MPP_HI:MPP_LO]    = 2'b11;
    stat_mret                   = csr_rdata;
    stat_mret[MIE_BIT]          = csr_rdata[MPIE_BIT];
    stat_mret[MPIE_BIT]         = 1'b1;
    stat_mret[MPP_HI:MPP_LO]    = 2'b11;
  end

  // Everything is forced quiet while rst_n is low so no port activity or
  // redirect can leak out of an aborted sequence.
  always_comb begin
    state_nxt      = state;
    ins_ready      = 1'b0;
    ins_rdata      = '0;
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_ena        = 1'b0;
    csr_write      = 1'b0;
    csr_idx        = '0;
    csr_wdata      = '0;
    busy           = 1'b0;
    if (rst_n) begin
      busy = (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (trap_valid) begin
            state_nxt = S_T_EPC;
          end else if (mret_valid) begin
            state_nxt = S_M_STAT;
          end else if (ins_valid) begin
            csr_ena   = 1'b1;
            csr_write = ins_write;
            csr_idx   = ins_idx;
            csr_wdata = ins_wdata;
            ins_rdata = csr_rdata;
            ins_ready = 1'b1;
          end
        end
        S_T_EPC: begin
          csr_ena   = 1'b1;
          csr_write = 1'b1;
          csr_idx   = CSR_IDX'(CSR_MEPC);
          csr_wdata = pc_q;
          state_nxt = S_T_CAUSE;
        end
        S_T_CAUSE: begin
          csr_ena   = 1'b1;
          csr_write = 1'b1;
          csr_idx   = CSR_IDX'(CSR_MCAUSE);
          csr_wdata = cause_q;
          state_nxt = S_T_STAT;
        end
        S_T_STAT: begin
          csr_ena   = 1'b1;
          csr_write = 1'b1;
          csr_idx   = CSR_IDX'(CSR_MSTATUS);
          csr_wdata = stat_trap;
          state_nxt = S_T_VEC;
        end
        S_T_VEC: begin
          csr_ena        = 1'b1;
          csr_idx        = CSR_IDX'(CSR_MTVEC);
          redirect_valid = 1'b1;
          redirect_pc    = {csr_rdata[XLEN-1:2], 2'b00};
          trap_ready     = 1'b1;
          state_nxt      = S_IDLE;
        end
        S_M_STAT: begin
          csr_ena   = 1'b1;
          csr_write = 1'b1;
          csr_idx   = CSR_IDX'(CSR_MSTATUS);
          csr_wdata = stat_mret;
          state_nxt = S_M_EPC;
        end
        S_M_EPC: begin
          csr_ena        = 1'b1;
          csr_idx        = CSR_IDX'(CSR_MEPC);
          redirect_valid = 1'b1;
          redirect_pc    = csr_rdata;
          mret_ready     = 1'b1;
          state_nxt      = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lieat_exu_com_csrctrl.sv
// Vector-table bench for the CSR port sequencer; per-cycle expectations are
// queued when driven and popped for comparison at the following negedge.
module tb_lieat_exu_com_csrctrl;

  logic        clock;
  logic        rst_n;
  logic        ins_valid, ins_ready, ins_write;
  logic [11:0] ins_idx;
  logic [31:0] ins_wdata, ins_rdata;
  logic        trap_valid, trap_ready;
  logic [31:0] trap_pc, trap_cause;
  logic        mret_valid, mret_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_ena, csr_write;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy;

  lieat_exu_com_csrctrl #(.XLEN(32), .CSR_IDX(12)) dut (
    .clock(clock), .rst_n(rst_n),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_write(ins_write),
    .ins_idx(ins_idx), .ins_wdata(ins_wdata), .ins_rdata(ins_rdata),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .trap_ready(trap_ready), .mret_valid(mret_valid), .mret_ready(mret_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_ena(csr_ena), .csr_write(csr_write), .csr_idx(csr_idx),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .busy(busy)
  );

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic        iw;
    logic [11:0] ix;
    logic [31:0] iwd;
    logic        tv;
    logic [31:0] tpc;
    logic [31:0] tc;
    logic        mv;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [11:0] ix;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] ird;
    logic        tr;
    logic        mr;
    logic        rv;
    logic [31:0] rpc;
    logic        bz;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic in_t mi(logic r, logic iv, logic iw, logic [11:0] ix, logic [31:0] iwd,
                             logic tv, logic [31:0] tpc, logic [31:0] tc, logic mv, logic [31:0] rd);
    in_t x;
    x.rst = r; x.iv = iv; x.iw = iw; x.ix = ix; x.iwd = iwd;
    x.tv = tv; x.tpc = tpc; x.tc = tc; x.mv = mv; x.rd = rd;
    return x;
  endfunction

  function automatic out_t mo(logic en, logic wr, logic [11:0] ix, logic [31:0] wd, logic rdy,
                              logic [31:0] ird, logic tr, logic mr, logic rv, logic [31:0] rpc,
                              logic bz);
    out_t x;
    x.en = en; x.wr = wr; x.ix = ix; x.wd = wd; x.rdy = rdy; x.ird = ird;
    x.tr = tr; x.mr = mr; x.rv = rv; x.rpc = rpc; x.bz = bz;
    return x;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    vecs.push_back(v);
  endtask

  function automatic out_t sample();
    return mo(csr_ena, csr_write, csr_idx, csr_wdata, ins_ready, ins_rdata,
              trap_ready, mret_ready, redirect_valid, redirect_pc, busy);
  endfunction

  task automatic drive(input in_t i);
    rst_n      = i.rst;
    ins_valid  = i.iv;
    ins_write  = i.iw;
    ins_idx    = i.ix;
    ins_wdata  = i.iwd;
    trap_valid = i.tv;
    trap_pc    = i.tpc;
    trap_cause = i.tc;
    mret_valid = i.mv;
    csr_rdata  = i.rd;
  endtask

  task automatic apply(input in_t i, input out_t e, input string name);
    out_t exp_v, act;
    @(posedge clock);
    #1;
    drive(i);
    exp_q.push_back(e);
    @(negedge clock);
    act   = sample();
    exp_v = exp_q.pop_front();
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  localparam out_t Z = '0;

  initial begin
    int cyc;
    logic seen;
    logic [31:0] rpc_seen;
    drive(mi(0, 0, 0, 12'h0, 0, 0, 0, 0, 0, 0));

    // reset quiet even with a request present, then idle
    add(mi(0, 1, 1, 12'h300, 32'h8, 0, 0, 0, 0, 32'h1800), Z);
    add(mi(1, 0, 0, 12'h0, 0, 0, 0, 0, 0, 32'h55), Z);
    // instruction pass-through
    add(mi(1, 1, 1, 12'h300, 32'h8, 0, 0, 0, 0, 32'h1800),
        mo(1, 1, 12'h300, 32'h8, 1, 32'h1800, 0, 0, 0, 0, 0));
    add(mi(1, 1, 0, 12'hB00, 0, 0, 0, 0, 0, 32'h1234),
        mo(1, 0, 12'hB00, 0, 1, 32'h1234, 0, 0, 0, 0, 0));
    // trap entry
    add(mi(1, 0, 0, 0, 0, 1, 32'h80000010, 32'd11, 0, 32'hDEAD), Z);
    add(mi(1, 0, 0, 0, 0, 1, 32'h80000010, 32'd11, 0, 0),
        mo(1, 1, 12'h341, 32'h80000010, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 1, 32'h80000010, 32'd11, 0, 0),
        mo(1, 1, 12'h342, 32'hB, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 1, 32'h80000010, 32'd11, 0, 32'h8),
        mo(1, 1, 12'h300, 32'h1880, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 1, 32'h80000010, 32'd11, 0, 32'h80000101),
        mo(1, 0, 12'h305, 0, 0, 0, 1, 0, 1, 32'h80000100, 1));
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z);
    // mret
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77), Z);
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1880),
        mo(1, 1, 12'h300, 32'h1888, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80000014),
        mo(1, 0, 12'h341, 0, 0, 0, 0, 1, 1, 32'h80000014, 1));
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z);
    // all three requesters at once: trap, then mret, then instruction
    add(mi(1, 1, 1, 12'h340, 32'h7, 1, 32'h100, 32'h2, 1, 32'h9), Z);
    add(mi(1, 1, 1, 12'h340, 32'h7, 1, 32'h100, 32'h2, 1, 32'h9),
        mo(1, 1, 12'h341, 32'h100, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 1, 1, 12'h340, 32'h7, 1, 32'h100, 32'h2, 1, 32'h9),
        mo(1, 1, 12'h342, 32'h2, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 1, 1, 12'h340, 32'h7, 1, 32'h100, 32'h2, 1, 32'h0),
        mo(1, 1, 12'h300, 32'h1800, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 1, 1, 12'h340, 32'h7, 1, 32'h100, 32'h2, 1, 32'h203),
        mo(1, 0, 12'h305, 0, 0, 0, 1, 0, 1, 32'h200, 1));
    add(mi(1, 1, 1, 12'h340, 32'h7, 0, 0, 0, 1, 32'h9), Z);
    add(mi(1, 1, 1, 12'h340, 32'h7, 0, 0, 0, 1, 32'h80),
        mo(1, 1, 12'h300, 32'h1888, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 1, 1, 12'h340, 32'h7, 0, 0, 0, 1, 32'h44),
        mo(1, 0, 12'h341, 0, 0, 0, 0, 1, 1, 32'h44, 1));
    add(mi(1, 1, 1, 12'h340, 32'h7, 0, 0, 0, 0, 32'h9),
        mo(1, 1, 12'h340, 32'h7, 1, 32'h9, 0, 0, 0, 0, 0));
    // trap_valid dropped mid-sequence; captured pc/cause must be used
    add(mi(1, 0, 0, 0, 0, 1, 32'h1000, 32'h80000007, 0, 0), Z);
    add(mi(1, 0, 0, 0, 0, 1, 32'h1000, 32'h80000007, 0, 0),
        mo(1, 1, 12'h341, 32'h1000, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 0, 32'hFFFF, 32'h1, 0, 0),
        mo(1, 1, 12'h342, 32'h80000007, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 0, 32'hFFFF, 32'h1, 0, 32'h88),
        mo(1, 1, 12'h300, 32'h1880, 0, 0, 0, 0, 0, 0, 1));
    add(mi(1, 0, 0, 0, 0, 0, 32'hFFFF, 32'h1, 0, 32'h300),
        mo(1, 0, 12'h305, 0, 0, 0, 1, 0, 1, 32'h300, 1));
    add(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), Z);

    foreach (vecs[k]) apply(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));

    // reset pulled in T_STAT: port goes quiet at once, then a fresh trap restarts
    apply(mi(1, 0, 0, 0, 0, 1, 32'h2000, 32'h3, 0, 0), Z, "rst_accept");
    apply(mi(1, 0, 0, 0, 0, 1, 32'h2000, 32'h3, 0, 0),
          mo(1, 1, 12'h341, 32'h2000, 0, 0, 0, 0, 0, 0, 1), "rst_epc");
    apply(mi(1, 0, 0, 0, 0, 1, 32'h2000, 32'h3, 0, 0),
          mo(1, 1, 12'h342, 32'h3, 0, 0, 0, 0, 0, 0, 1), "rst_cause");
    apply(mi(0, 0, 0, 0, 0, 1, 32'h2000, 32'h3, 0, 32'h8), Z, "rst_in_stat");
    apply(mi(0, 0, 0, 0, 0, 1, 32'h2000, 32'h3, 0, 32'h305), Z, "rst_held");
    apply(mi(1, 0, 0, 0, 0, 1, 32'h3000, 32'h5, 0, 32'h407), Z, "restart_accept");
    apply(mi(1, 0, 0, 0, 0, 1, 32'h3000, 32'h5, 0, 32'h407),
          mo(1, 1, 12'h341, 32'h3000, 0, 0, 0, 0, 0, 0, 1), "restart_epc");

    // bounded wait for completion of the restarted trap
    cyc  = 0;
    seen = 1'b0;
    rpc_seen = '0;
    while (!seen && cyc < 10) begin
      @(negedge clock);
      cyc++;
      if (trap_ready) begin
        seen     = 1'b1;
        rpc_seen = redirect_pc;
      end
    end
    check("restart_done", {31'd0, seen}, 32'd1);
    check("restart_latency", cyc, 32'd3);
    check("restart_redirect", rpc_seen, 32'h404);

    @(posedge clock);
    #1;
    drive(mi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    check("final_idle", {31'd0, busy}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
